noc_traffic_injector: RTL and testbench

Parametrised synthesizable packet injector that sits at a mesh node's local port and drives the router's local input via the ReqDnStr/GntDnStr/DnStrFull handshake.
- Successor to the fixed per-node injectors: node coordinates, mesh size and packet budget are parameters, not hard-coded destination tables.
- Randomness comes from an internal LFSR instead of $random.
- Adds runtime-selectable traffic patterns (uniform, transpose, bit-complement, hotspot), an enable, a packet budget with done flag, and timestamp/count outputs for the traffic generator.

---
 rtl/noc_pkg.sv | 66 ++++++
 rtl/noc_lfsr16.sv | 29 ++
 rtl/noc_traffic_injector.sv | 209 ++++++++++++++++++++
 tb/tb_noc_traffic_injector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh traffic injector and its neighbours
// (routers, ejector): mode and state encodings, LFSR taps, packet field
// offsets and the per-axis destination encoder.
package noc_pkg;

    // Traffic pattern selectors.
    localparam logic [1:0] MODE_UNIFORM    = 2'd0;
    localparam logic [1:0] MODE_TRANSPOSE  = 2'd1;
    localparam logic [1:0] MODE_COMPLEMENT = 2'd2;
    localparam logic [1:0] MODE_HOTSPOT    = 2'd3;

    // Injector FSM states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PKT_PREP   = 3'd1,
        ST_WAIT_SLOT  = 3'd2,
        ST_WAIT_GRANT = 3'd3,
        ST_DONE       = 3'd4
    } inj_state_e;

    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Packet layout, LSB first: MODULE_ID, PacketID, ySrc, xSrc, yDst, xDst.
    localparam int PKT_MOD_LSB  = 0;
    localparam int PKT_MOD_W    = 6;
    localparam int PKT_ID_LSB   = 6;
    localparam int PKT_ID_W     = 10;
    localparam int PKT_HDR_LSB  = 16;

    function automatic int pkt_ysrc_lsb(input int dim);
        return PKT_HDR_LSB;
    endfunction

    function automatic int pkt_xsrc_lsb(input int dim);
        return PKT_HDR_LSB + dim;
    endfunction

    function automatic int pkt_ydst_lsb(input int dim);
        return PKT_HDR_LSB + 2 * dim;
    endfunction

    function automatic int pkt_xdst_lsb(input int dim);
        return PKT_HDR_LSB + 3 * dim;
    endfunction

    // Encode one axis as {dir, offset}. Bit 7 is the direction, bits 6:0 the
    // zero-extended offset. dir_if_greater selects which sign sets dir:
    // x axis uses 1 (east when dst > src), y axis uses 0 (north when dst < src).
    // Equal coordinates give an all-zero field.
    function automatic logic [7:0] axis_field(input logic [2:0] dst,
                                              input logic [2:0] src,
                                              input logic       dir_if_greater);
        logic [7:0] f;
        f = '0;
        if (dst > src) begin
            f[7]   = dir_if_greater;
            f[2:0] = dst - src;
        end else if (dst < src) begin
            f[7]   = !dir_if_greater;
            f[2:0] = src - dst;
        end
        return f;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR, free-running (advances every clock).
// Ports: clk_i, rst_i (async, active-high), lfsr_o (current state).
// A zero seed would lock up the register, so it is replaced by 16'h0001.
module noc_lfsr16
    import noc_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= SEED_NZ;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/noc_traffic_injector.sv
// Packet injector for a mesh node's local port.
// Ports: clk, reset (async, active-high), enable, mode (traffic pattern),
// DnStrFull / GntDnStr (router handshake inputs), ReqDnStr, PacketOut,
// TimeStamp (cycle count at request rise), PktCount, Done, dbg_state_o
// (current FSM state).
// Handshake: ReqDnStr rises with PacketOut valid and both stay constant
// until an edge samples GntDnStr=1; that edge ends the transfer.
module noc_traffic_injector
    import noc_pkg::*;
#(
    parameter int          MESH_X      = 5,
    parameter int          MESH_Y      = 5,
    parameter int          NODE_X      = 0,
    parameter int          NODE_Y      = 0,
    parameter int          DIM         = 4,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [5:0]  MODULE_ID   = 6'b000_000,
    parameter int          MAX_PACKETS = 1023,
    parameter int          DELAY_BITS  = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          HOT_X       = 2,
    parameter int          HOT_Y       = 2,
    parameter int          HOT_PCT     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  DnStrFull,
    input  logic                  GntDnStr,
    output logic                  ReqDnStr,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic [31:0]           TimeStamp,
    output logic [9:0]            PktCount,
    output logic                  Done,
    output logic [2:0]            dbg_state_o
);
    localparam logic [3:0] MX   = 4'(MESH_X);
    localparam logic [3:0] MY   = 4'(MESH_Y);
    localparam logic [2:0] NX   = 3'(NODE_X);
    localparam logic [2:0] NY   = 3'(NODE_Y);
    localparam logic [2:0] HX   = 3'(HOT_X);
    localparam logic [2:0] HY   = 3'(HOT_Y);
    localparam logic [2:0] CX   = 3'(MESH_X - 1 - NODE_X);
    localparam logic [2:0] CY   = 3'(MESH_Y - 1 - NODE_Y);
    localparam logic [7:0] HPCT = 8'(HOT_PCT);
    localparam logic [9:0] MAXP = 10'(MAX_PACKETS);
    // Transposed coordinates that fall outside the mesh degrade to self.
    localparam bit T_OK = (NODE_Y < MESH_X) && (NODE_X < MESH_Y);

    logic [15:0] lfsr;

    noc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_i  (reset),
        .lfsr_o (lfsr)
    );

    inj_state_e              state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [DELAY_BITS-1:0]   delay_q, delay_d;
    logic [DELAY_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   pkt_q, pkt_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [31:0]             ts_q, ts_d;
    logic [9:0]              pkt_cnt_q, pkt_cnt_d;
    logic                    done_q, done_d;
    logic [31:0]             cyc_q;

    // Destination resolution for the latched mode.
    logic [2:0] dst_x, dst_y;
    logic       dst_ok;      // coordinates lie inside the mesh
    logic       redraw;      // a bad draw retries instead of abandoning
    logic       is_self;
    logic [7:0] ax, ay;
    logic [DATA_WIDTH-1:0] pkt_word;

    always_comb begin
        dst_x  = lfsr[2:0];
        dst_y  = lfsr[5:3];
        dst_ok = ({1'b0, lfsr[2:0]} < MX) && ({1'b0, lfsr[5:3]} < MY);
        redraw = 1'b1;
        unique case (mode_q)
            MODE_TRANSPOSE: begin
                redraw = 1'b0;
                dst_ok = 1'b1;
                dst_x  = T_OK ? NY : NX;
                dst_y  = T_OK ? NX : NY;
            end
            MODE_COMPLEMENT: begin
                redraw = 1'b0;
                dst_ok = 1'b1;
                dst_x  = CX;
                dst_y  = CY;
            end
            MODE_HOTSPOT: begin
                if ({1'b0, lfsr[12:6]} < HPCT) begin
                    dst_ok = 1'b1;
                    dst_x  = HX;
                    dst_y  = HY;
                end
            end
            default: ;
        endcase
        is_self  = (dst_x == NX) && (dst_y == NY);
        ax       = axis_field(dst_x, NX, 1'b1);
        ay       = axis_field(dst_y, NY, 1'b0);
        pkt_word = {ax[7], ax[DIM-2:0], ay[7], ay[DIM-2:0],
                    {(2*DIM){1'b0}}, pkt_cnt_q, MODULE_ID};
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        req_d     = req_q;
        out_d     = out_q;
        ts_d      = ts_q;
        pkt_cnt_d = pkt_cnt_q;
        done_d    = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !done_q) begin
                    mode_d  = mode;
                    delay_d = lfsr[15 -: DELAY_BITS];
                    cnt_d   = '0;
                    state_d = ST_PKT_PREP;
                end
            end
            ST_PKT_PREP: begin
                if (!dst_ok || is_self) begin
                    // Random patterns try again next cycle; fixed patterns
                    // can never improve, so give up without a packet.
                    if (!redraw) state_d = ST_IDLE;
                end else begin
                    pkt_d   = pkt_word;
                    state_d = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                // The gap keeps counting while the FIFO is full; once it has
                // elapsed, the request is held back only by DnStrFull.
                if (cnt_q != delay_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!DnStrFull) begin
                    req_d   = 1'b1;
                    out_d   = pkt_q;
                    ts_d    = cyc_q;
                    state_d = ST_WAIT_GRANT;
                end
            end
            ST_WAIT_GRANT: begin
                if (GntDnStr) begin
                    req_d     = 1'b0;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    if (pkt_cnt_q + 10'd1 == MAXP) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                req_d  = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_UNIFORM;
            delay_q   <= '0;
            cnt_q     <= '0;
            pkt_q     <= '0;
            req_q     <= 1'b0;
            out_q     <= '0;
            ts_q      <= '0;
            pkt_cnt_q <= '0;
            done_q    <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            delay_q   <= delay_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            req_q     <= req_d;
            out_q     <= out_d;
            ts_q      <= ts_d;
            pkt_cnt_q <= pkt_cnt_d;
            done_q    <= done_d;
            cyc_q     <= cyc_q + 32'd1;
        end
    end

    assign ReqDnStr    = req_q;
    assign PacketOut   = out_q;
    assign TimeStamp   = ts_q;
    assign PktCount    = pkt_cnt_q;
    assign Done        = done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_noc_traffic_injector.sv
module tb_noc_traffic_injector;
  import noc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: node (0,0), 5x5, hotspot always hits (2,2)
  logic        m_rst, m_en, m_full, m_gnt, m_req, m_done;
  logic [1:0]  m_mode;
  logic [31:0] m_pkt, m_ts;
  logic [9:0]  m_cnt;
  logic [2:0]  m_st;

  // budget DUT: node (0,0), 5x5, 3 packets
  logic        b_rst, b_en, b_full, b_gnt, b_req, b_done;
  logic [1:0]  b_mode;
  logic [31:0] b_pkt, b_ts;
  logic [9:0]  b_cnt;
  logic [2:0]  b_st;

  localparam logic [5:0] M_ID = 6'b101_011;

  noc_traffic_injector #(
    .MESH_X(5), .MESH_Y(5), .NODE_X(0), .NODE_Y(0), .DIM(4), .DATA_WIDTH(32),
    .MODULE_ID(M_ID), .MAX_PACKETS(1023), .DELAY_BITS(4), .LFSR_SEED(16'hACE1),
    .HOT_X(2), .HOT_Y(2), .HOT_PCT(128)
  ) dut_m (
    .clk(clk), .reset(m_rst), .enable(m_en), .mode(m_mode), .DnStrFull(m_full),
    .GntDnStr(m_gnt), .ReqDnStr(m_req), .PacketOut(m_pkt), .TimeStamp(m_ts),
    .PktCount(m_cnt), .Done(m_done), .dbg_state_o(m_st)
  );

  noc_traffic_injector #(
    .MESH_X(5), .MESH_Y(5), .NODE_X(0), .NODE_Y(0), .DIM(4), .DATA_WIDTH(32),
    .MODULE_ID(6'b000_000), .MAX_PACKETS(3), .DELAY_BITS(4), .LFSR_SEED(16'h1234),
    .HOT_X(2), .HOT_Y(2), .HOT_PCT(32)
  ) dut_b (
    .clk(clk), .reset(b_rst), .enable(b_en), .mode(b_mode), .DnStrFull(b_full),
    .GntDnStr(b_gnt), .ReqDnStr(b_req), .PacketOut(b_pkt), .TimeStamp(b_ts),
    .PktCount(b_cnt), .Done(b_done), .dbg_state_o(b_st)
  );

  // reference cycle counter for dut_m timestamps
  logic [31:0] tb_cyc;
  always @(posedge clk or posedge m_rst) begin
    if (m_rst) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  next_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input logic [3:0] xf, input logic [3:0] yf,
                                         input logic [9:0] id);
    return {xf, yf, 8'h00, id, M_ID};
  endfunction

  // ---------------- driver tasks (dut_m) ----------------
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = m_req;
    end
  endtask

  // called at the first negedge with ReqDnStr high
  task automatic compare_req(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_packet"}, m_pkt, e);
      check({name, "_timestamp"}, m_ts, tb_cyc - 32'd1);
    end
  endtask

  // withhold grant for 'hold' cycles (DnStrFull toggling), then grant once
  task automatic grant_pkt(input int hold, input logic [9:0] exp_cnt);
    logic [31:0] held;
    bit stable;
    held = m_pkt;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      m_full = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (m_req !== 1'b1 || m_pkt !== held) stable = 1'b0;
    end
    if (hold > 0) check("req_pkt_held", stable, 1);
    m_full = 1'b0;
    m_gnt = 1'b1;
    @(posedge clk); #1;
    check("req_drop_after_grant", m_req, 0);
    check("pktcount_after_grant", m_cnt, exp_cnt);
    @(negedge clk);
    m_gnt = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] mode;
    int         npkt;
    logic [3:0] xf;
    logic [3:0] yf;
    bit         expect_req;
  } vec_t;
  vec_t vecs[3];

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    bit ok, bad, saw_prep;
    int rises;
    logic prev;
    logic [2:0] col, row;

    vecs[0] = '{mode: MODE_COMPLEMENT, npkt: 3, xf: 4'b1_100, yf: 4'b0_100, expect_req: 1'b1};
    vecs[1] = '{mode: MODE_HOTSPOT,    npkt: 3, xf: 4'b1_010, yf: 4'b0_010, expect_req: 1'b1};
    vecs[2] = '{mode: MODE_TRANSPOSE,  npkt: 0, xf: 4'b0_000, yf: 4'b0_000, expect_req: 1'b0};

    m_rst = 1; m_en = 0; m_mode = 0; m_full = 0; m_gnt = 0;
    b_rst = 1; b_en = 0; b_mode = 0; b_full = 0; b_gnt = 0;
    next_id = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req", m_req, 0);
    check("rst_packet", m_pkt, 0);
    check("rst_timestamp", m_ts, 0);
    check("rst_pktcount", m_cnt, 0);
    check("rst_done", m_done, 0);
    check("rst_state", m_st, ST_IDLE);
    m_rst = 0; b_rst = 0;
    @(negedge clk);

    // ---- table-driven patterns ----
    for (int v = 0; v < 3; v++) begin
      m_mode = vecs[v].mode;
      m_en = 1'b1;
      if (vecs[v].expect_req) begin
        for (int k = 0; k < vecs[v].npkt; k++) begin
          exp_q.push_back(mk_pkt(vecs[v].xf, vecs[v].yf, next_id));
          wait_req(ok);
          check("req_rise", ok, 1);
          if (!ok) begin
            exp_q.delete();
            break;
          end
          compare_req("pattern");
          next_id++;
          // first packet of the table: grant withheld 50 cycles
          grant_pkt((v == 0 && k == 0) ? 50 : $urandom_range(0, 3), next_id);
          if (k == vecs[v].npkt - 1) m_en = 1'b0;
        end
      end else begin
        bad = 1'b0;
        saw_prep = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (m_req !== 1'b0 || !(m_st == ST_IDLE || m_st == ST_PKT_PREP)) bad = 1'b1;
          if (m_st == ST_PKT_PREP) saw_prep = 1'b1;
        end
        check("self_no_request", bad, 0);
        check("self_cycles_prep", saw_prep, 1);
        check("self_pktcount", m_cnt, next_id);
        m_en = 1'b0;
        repeat (2) @(negedge clk);
      end
    end

    // ---- DnStrFull held 20 cycles in WAIT_SLOT ----
    m_mode = MODE_COMPLEMENT;
    m_full = 1'b1;
    m_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (m_st == ST_WAIT_SLOT);
    end
    check("full_reach_wait_slot", ok, 1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_req !== 1'b0 || m_st !== ST_WAIT_SLOT) bad = 1'b1;
    end
    check("full_blocks_request", bad, 0);
    exp_q.push_back(mk_pkt(4'b1_100, 4'b0_100, next_id));
    m_full = 1'b0;
    @(posedge clk); #1;
    check("req_after_release", m_req, 1);
    compare_req("release");
    next_id++;
    @(negedge clk);
    m_en = 1'b0;
    grant_pkt(2, next_id);

    // ---- reset during WAIT_GRANT (hotspot) ----
    m_mode = MODE_HOTSPOT;
    m_en = 1'b1;
    exp_q.push_back(mk_pkt(4'b1_010, 4'b0_010, next_id));
    wait_req(ok);
    check("hot_req_rise", ok, 1);
    if (ok) compare_req("hot");
    else exp_q.delete();
    #2 m_rst = 1'b1;
    #1;
    check("async_rst_req", m_req, 0);
    check("async_rst_pktcount", m_cnt, 0);
    check("async_rst_state", m_st, ST_IDLE);
    @(negedge clk);
    m_rst = 1'b0;
    next_id = '0;
    exp_q.push_back(mk_pkt(4'b1_010, 4'b0_010, next_id));
    wait_req(ok);
    check("post_rst_req_rise", ok, 1);
    if (ok) begin
      compare_req("post_rst");
      next_id++;
      m_en = 1'b0;
      grant_pkt(1, next_id);
    end else begin
      exp_q.delete();
    end
    m_en = 1'b0;

    // ---- packet budget of 3, uniform, random grants ----
    b_mode = MODE_UNIFORM;
    b_en = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 4000 && !b_done; i++) begin
      @(negedge clk);
      if (b_req && !prev) begin
        col = b_pkt[30:28];
        row = b_pkt[26:24];
        check("uni_x_dir", b_pkt[31], (col != 3'd0));
        check("uni_y_dir", b_pkt[27], 0);
        check("uni_in_range_not_self",
              (col < 3'd5) && (row < 3'd5) && !(col == 3'd0 && row == 3'd0), 1);
        check("uni_src_zero", b_pkt[23:16], 0);
        check("uni_id", b_pkt[15:6], rises);
        check("uni_module_id", b_pkt[5:0], 0);
        rises++;
      end
      prev = b_req;
      b_gnt = b_req ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    b_gnt = 1'b0;
    check("budget_done", b_done, 1);
    check("budget_requests", rises, 3);
    check("budget_pktcount", b_cnt, 3);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_req !== 1'b0 || b_done !== 1'b1 || b_st !== ST_DONE) bad = 1'b1;
    end
    check("done_sticky_no_request", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
